// File: rtl/cnn_spike_tx.sv
// AER transmit encoder: scans a CNN feature buffer and offers one time-to-first-spike
// event per feature above threshold, then holds the last-pixel flag until inference completes.
module cnn_spike_tx #(
  parameter int NUM_FEATURES = 320,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 9,
  parameter int T_MAX        = 255,
  parameter int SHIFT        = 0,
  parameter int THRESH       = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic [ADDR_W-1:0]        o_fm_addr,
  input  logic signed [DATA_W-1:0] i_fm_rdata,
  output logic                     o_spike_valid,
  output logic [DATA_W-1:0]        o_spike_time,
  output logic [ADDR_W-1:0]        o_spike_addr,
  input  logic                     i_spike_ack,
  output logic                     o_last_pixel_sent,
  input  logic                     i_inference_done,
  output logic [ADDR_W:0]          o_spike_count,
  output logic                     o_done
);

  typedef enum logic [2:0] {IDLE, FETCH, EVAL, OFFER, FINAL, LAST} state_t;

  localparam logic signed [DATA_W-1:0] TMAX_S    = DATA_W'(T_MAX);
  localparam logic signed [DATA_W-1:0] THRESH_S  = DATA_W'(THRESH);
  localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(NUM_FEATURES - 1);

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    addr;
  logic [ADDR_W:0]      count;
  logic                 dummy;
  logic [DATA_W-1:0]    spike_time;
  logic [ADDR_W-1:0]    spike_addr;
  logic                 done_q;
  logic                 fire;
  logic                 fires_spike;
  logic                 at_last;
  logic                 need_dummy;

  // Larger features fire earlier; the shifted value is clamped so time stays in [0, T_MAX].
  function automatic logic [DATA_W-1:0] encode_time(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] s;
    s = v >>> SHIFT;
    if (s < 0)
      s = '0;
    else if (s > TMAX_S)
      s = TMAX_S;
    return $unsigned(TMAX_S - s);
  endfunction

  assign fire        = (state == OFFER) && i_spike_ack;
  assign fires_spike = i_fm_rdata > THRESH_S;
  assign at_last     = (addr == LAST_ADDR);
  assign need_dummy  = (count == '0) && !dummy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (i_start) state_nxt = FETCH;
      FETCH: state_nxt = EVAL;
      EVAL: begin
        if (fires_spike)  state_nxt = OFFER;
        else if (at_last) state_nxt = FINAL;
        else              state_nxt = FETCH;
      end
      OFFER: if (i_spike_ack) state_nxt = (dummy || at_last) ? FINAL : FETCH;
      FINAL: state_nxt = need_dummy ? OFFER : LAST;
      LAST:  if (i_inference_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      count      <= '0;
      dummy      <= 1'b0;
      spike_time <= '0;
      spike_addr <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state == LAST) && i_inference_done;
      case (state)
        IDLE: begin
          if (i_start) begin
            addr  <= '0;
            count <= '0;
            dummy <= 1'b0;
          end
        end
        EVAL: begin
          if (fires_spike) begin
            spike_time <= encode_time(i_fm_rdata);
            spike_addr <= addr;
          end else if (!at_last) begin
            addr <= addr + ADDR_W'(1);
          end
        end
        OFFER: begin
          if (fire) begin
            if (!dummy)
              count <= count + (ADDR_W + 1)'(1);
            if (!dummy && !at_last)
              addr <= addr + ADDR_W'(1);
          end
        end
        // An all-silent frame still emits one spike so the consumer starts its inference.
        FINAL: begin
          if (need_dummy) begin
            dummy      <= 1'b1;
            spike_addr <= '0;
            spike_time <= DATA_W'(T_MAX);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy            = (state != IDLE);
  assign o_fm_addr         = addr;
  assign o_spike_valid     = (state == OFFER);
  assign o_spike_time      = spike_time;
  assign o_spike_addr      = spike_addr;
  assign o_last_pixel_sent = (state == LAST);
  assign o_spike_count     = count;
  assign o_done            = done_q;

endmodule

// File: tb/tb_cnn_spike_tx.sv
// Scoreboard bench for cnn_spike_tx: expected spikes are queued when a frame is loaded
// and popped as the DUT completes each valid/ack transfer.
module tb_cnn_spike_tx;
  localparam int NF = 320;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int TM = 255;

  typedef struct {
    int addr;
    int tm;
  } spk_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 ack = 1'b1;
  logic                 inf_done = 1'b0;
  logic signed [DW-1:0] rdata = '0;
  logic                 busy, valid, last, done;
  logic [AW-1:0]        fm_addr, spike_addr;
  logic [DW-1:0]        spike_time;
  logic [AW:0]          count;

  logic signed [DW-1:0] mem [NF];
  spk_t q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit ack_low = 0;
  int stall_addr = -1;
  int stall_len = 0;
  int stall_cnt = 0;
  bit spacing_en = 0;
  int last_xfer = -1;

  cnn_spike_tx dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .o_busy(busy), .o_fm_addr(fm_addr),
    .i_fm_rdata(rdata), .o_spike_valid(valid), .o_spike_time(spike_time),
    .o_spike_addr(spike_addr), .i_spike_ack(ack), .o_last_pixel_sent(last),
    .i_inference_done(inf_done), .o_spike_count(count), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) rdata <= mem[fm_addr];

  // Ack driver and scoreboard consumer, both on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && int'(spike_addr) == stall_addr && stall_cnt < stall_len) begin
        ack = 1'b0;
        stall_cnt++;
        checks++;
        if (spike_time !== 245 || spike_addr !== 5 || fm_addr !== 5) begin
          errors++;
          $display("FAIL stall_hold: time=%0d addr=%0d fm_addr=%0d required 245/5/5",
                   spike_time, spike_addr, fm_addr);
        end
      end else begin
        ack = !ack_low;
      end
      if (valid && ack) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_spike: addr=%0d time=%0d required none", spike_addr, spike_time);
        end else begin
          spk_t e;
          e = q.pop_front();
          if (int'(spike_addr) != e.addr || int'(spike_time) != e.tm) begin
            errors++;
            $display("FAIL spike: addr=%0d time=%0d required addr=%0d time=%0d",
                     spike_addr, spike_time, e.addr, e.tm);
          end
        end
        if (spacing_en) begin
          if (last_xfer >= 0) begin
            checks++;
            if (cyc - last_xfer != 3) begin
              errors++;
              $display("FAIL spacing: got %0d cycles required 3", cyc - last_xfer);
            end
          end
          last_xfer = cyc;
        end
      end
    end
  end

  function automatic int exp_time(input int v);
    int s;
    s = v;
    if (s > TM) s = TM;
    return TM - s;
  endfunction

  task automatic load_frame(input int pattern);
    spk_t e;
    for (int i = 0; i < NF; i++) begin
      case (pattern)
        0: mem[i] = 10;
        1: mem[i] = (i % 2 == 1) ? 300 : 0;
        default: mem[i] = (i % 3 == 0) ? 0 : -(i + 1);
      endcase
      if (mem[i] > 0) begin
        e.addr = i;
        e.tm   = exp_time(int'(mem[i]));
        q.push_back(e);
      end
    end
    if (pattern == 2) begin
      e.addr = 0;
      e.tm   = TM;
      q.push_back(e);
    end
  endtask

  task automatic check_eq(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic start_with_latency();
    pulse_start();
    check_eq("lat_busy", int'(busy), 1);
    check_eq("lat_valid_c1", int'(valid), 0);
    @(posedge clk); #1;
    check_eq("lat_valid_c2", int'(valid), 0);
    @(posedge clk); #1;
    check_eq("lat_valid_c3", int'(valid), 1);
    check_eq("lat_addr_c3", int'(spike_addr), 0);
  endtask

  task automatic wait_last();
    int n = 0;
    while (!last && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("last_timeout", int'(last), 1);
  endtask

  task automatic finish_frame(input int exp_count);
    wait_last();
    check_eq("queue_empty", q.size(), 0);
    check_eq("spike_count", int'(count), exp_count);
    check_eq("busy_in_last", int'(busy), 1);
    @(posedge clk); #1 inf_done = 1'b1;
    @(posedge clk); #1 inf_done = 1'b0;
    check_eq("done_pulse", int'(done), 1);
    check_eq("busy_after_done", int'(busy), 0);
    check_eq("last_after_done", int'(last), 0);
    check_eq("count_held", int'(count), exp_count);
    @(posedge clk); #1;
    check_eq("done_one_cycle", int'(done), 0);
  endtask

  task automatic check_all_zero(input string nm);
    check_eq({nm, "_busy"}, int'(busy), 0);
    check_eq({nm, "_fm_addr"}, int'(fm_addr), 0);
    check_eq({nm, "_valid"}, int'(valid), 0);
    check_eq({nm, "_time"}, int'(spike_time), 0);
    check_eq({nm, "_addr"}, int'(spike_addr), 0);
    check_eq({nm, "_last"}, int'(last), 0);
    check_eq({nm, "_count"}, int'(count), 0);
    check_eq({nm, "_done"}, int'(done), 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NF; i++) mem[i] = 0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1 check_all_zero("post_reset");
  endtask

  task automatic test_all_ten();
    load_frame(0);
    spacing_en = 1;
    last_xfer  = -1;
    start_with_latency();
    wait_last();
    spacing_en = 0;
    finish_frame(320);
  endtask

  task automatic test_alternate();
    load_frame(1);
    pulse_start();
    finish_frame(160);
  endtask

  task automatic test_silent();
    load_frame(2);
    pulse_start();
    finish_frame(0);
  endtask

  task automatic test_stall_and_ignored_start();
    int n = 0;
    load_frame(0);
    stall_cnt  = 0;
    stall_len  = 20;
    stall_addr = 5;
    pulse_start();
    while (stall_cnt < 5 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("stall_reached", int'(stall_cnt >= 5), 1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_last();
    check_eq("stall_len", stall_cnt, 20);
    stall_addr = -1;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq("start_in_last_last", int'(last), 1);
    check_eq("start_in_last_busy", int'(busy), 1);
    check_eq("stall_frame_count", int'(count), 320);
    inf_done = 1'b1;
    @(posedge clk); #1 inf_done = 1'b0;
    check_eq("done_before_restart", int'(done), 1);
    load_frame(0);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq("restart_count_cleared", int'(count), 0);
    check_eq("restart_busy", int'(busy), 1);
    check_eq("restart_done_low", int'(done), 0);
    finish_frame(320);
  endtask

  task automatic test_reset_mid_offer();
    int n = 0;
    load_frame(0);
    ack_low = 1;
    pulse_start();
    while (!valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("offer_reached", int'(valid), 1);
    rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    q.delete();
    ack_low = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    load_frame(0);
    start_with_latency();
    finish_frame(320);
  endtask

  initial begin
    test_reset();
    test_all_ten();
    test_alternate();
    test_silent();
    test_stall_and_ignored_start();
    test_reset_mid_offer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
